sequential_divider_16x8: RTL and testbench
==========================================

SEQUENTIAL_DIVIDER_16X8 -- requirements
Module: sequential_divider_16x8

Interface
REQ-001 SHALL have parameter APPROX_LSBS, default 0, giving the number of low quotient bits not computed and forced to 0 (legal range 0..4).
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: an operand pair is presented.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-006 SHALL have port dividend, input, 16 bits: unsigned dividend.
REQ-007 SHALL have port divisor, input, 8 bits: unsigned divisor.
REQ-008 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 SHALL have port quotient, output, 8 bits: unsigned quotient.
REQ-011 SHALL have port remainder, output, 8 bits: unsigned remainder.
REQ-012 SHALL have port div_by_zero, output, 1 bit: the divisor was 0.
REQ-013 SHALL have port overflow, output, 1 bit: the quotient does not fit in 8 bits.

Function
REQ-014 SHALL implement states IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 An operand pair SHALL be accepted in IDLE when in_valid=1, and the operands SHALL be latched on that edge.
REQ-016 On accept with divisor=0, the block SHALL go to DONE with div_by_zero=1, overflow=0, quotient=8'hFF and remainder=dividend[7:0].
REQ-017 On accept with divisor≠0 and dividend[15:8]>=divisor, the block SHALL go to DONE with overflow=1, div_by_zero=0, quotient=8'hFF and remainder=8'h00.
REQ-018 Otherwise, on accept, the block SHALL go to BUSY with an iteration counter loaded to N = 8 − APPROX_LSBS.
REQ-019 Each BUSY cycle SHALL perform one restoring-division step:
- 9-bit partial remainder = {partial remainder, next dividend bit, MSB first}.
- If the partial remainder is >= divisor, subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
- Decrement the counter.
REQ-020 The partial remainder SHALL be initialised to dividend[15:8], and the next dividend bits SHALL be dividend[7:0], MSB first.
REQ-021 After the Nth step, the block SHALL go to DONE with quotient = {computed N bits, APPROX_LSBS zeros}.
REQ-022 The remainder after the Nth step SHALL equal the final partial remainder when APPROX_LSBS=0, and SHALL be 8'h00 otherwise.
REQ-023 Latency SHALL be exactly N+1 cycles from the accepting edge to the first cycle with out_valid=1 for the normal path, and 1 cycle for the zero-divisor and overflow paths.
REQ-024 In DONE, quotient, remainder, div_by_zero and overflow SHALL hold stable while out_valid=1 and out_ready=0 (backpressure of unbounded length).
REQ-025 DONE with out_ready=1 SHALL return the block to IDLE on the next edge; no new accept SHALL occur in the same cycle as a result handshake.
REQ-026 Changes on dividend, divisor or in_valid while in BUSY or DONE SHALL have no effect.
REQ-027 After leaving DONE, the result outputs SHALL retain their last values until the next result is produced; only out_valid qualifies them.

Reset
REQ-028 RST=1 on a rising edge SHALL force state to IDLE and clear quotient, remainder, div_by_zero, overflow, out_valid, counter and partial remainder to 0, regardless of the current state.
REQ-029 A reset during BUSY or DONE SHALL discard the operation in progress, and no out_valid SHALL follow it.
REQ-030 in_ready SHALL be 1 in the first cycle after RST deasserts.

Verification
REQ-031 Bench: APPROX_LSBS=0, dividend=1000, divisor=10, out_ready=1 -> out_valid 9 cycles after accept, quotient=100, remainder=0, both flags 0.
REQ-032 Bench: APPROX_LSBS=0, dividend=16'h0FFF, divisor=8'h10 -> quotient=8'hFF, remainder=8'h0F; then dividend=16'h1000, divisor=8'h10 -> overflow=1, quotient=8'hFF, remainder=0, one-cycle latency.
REQ-033 Bench: dividend=16'h1234, divisor=0 -> div_by_zero=1, quotient=8'hFF, remainder=8'h34, out_valid on the cycle after accept.
REQ-034 Bench: APPROX_LSBS=2, dividend=1023, divisor=10 -> out_valid 7 cycles after accept, quotient=100 (exact 102), remainder=0.
REQ-035 Bench: hold out_ready=0 for 20 cycles in DONE -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE and in_ready=1 on the next cycle.
REQ-036 Bench: assert RST in the 3rd BUSY cycle -> next cycle IDLE, all outputs 0, in_ready=1, and no out_valid pulse.

Source files
------------

// File: rtl/sequential_divider_16x8.sv
// 16/8 unsigned restoring divider, one quotient bit per cycle.
// Optional truncation of low quotient bits via APPROX_LSBS.
module sequential_divider_16x8 #(
  parameter int APPROX_LSBS = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero,
  output logic        overflow
);

  localparam logic [3:0] N_ITER = 4'(8 - APPROX_LSBS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [7:0] div_r;
  logic [7:0] lo_bits;
  logic [7:0] prem;
  logic [7:0] quo;
  logic [3:0] cnt;

  logic       dbz_in;
  logic       ovf_in;
  logic [8:0] trial;
  logic [8:0] diff;
  logic       q_bit;
  logic [7:0] prem_nx;
  logic [7:0] quo_nx;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign dbz_in = (divisor == 8'h00);
  assign ovf_in = !dbz_in && (dividend[15:8] >= divisor);

  // One restoring step: bring down the next dividend bit, trial-subtract.
  assign trial   = {prem, lo_bits[7]};
  assign diff    = trial - {1'b0, div_r};
  assign q_bit   = (trial >= {1'b0, div_r});
  assign prem_nx = q_bit ? diff[7:0] : trial[7:0];
  assign quo_nx  = {quo[6:0], q_bit};

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (in_valid)
          state_nx = (dbz_in || ovf_in) ? DONE : BUSY;
      end
      BUSY: begin
        if (cnt == 4'd1) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_r       <= '0;
      lo_bits     <= '0;
      prem        <= '0;
      quo         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            div_r   <= divisor;
            lo_bits <= dividend[7:0];
            prem    <= dividend[15:8];
            quo     <= '0;
            cnt     <= N_ITER;
            if (dbz_in) begin
              quotient    <= 8'hFF;
              remainder   <= dividend[7:0];
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end else if (ovf_in) begin
              quotient    <= 8'hFF;
              remainder   <= 8'h00;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
            end
          end
        end
        BUSY: begin
          prem    <= prem_nx;
          lo_bits <= {lo_bits[6:0], 1'b0};
          quo     <= quo_nx;
          cnt     <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            // Computed bits sit low in quo; align them above the skipped LSBs.
            quotient    <= quo_nx << APPROX_LSBS;
            remainder   <= (APPROX_LSBS == 0) ? prem_nx : 8'h00;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_divider_16x8.sv
// Bench for sequential_divider_16x8: exact and 2-LSB-approximate instances,
// directed vector table, reset-in-BUSY sequence and random model checks.
module tb_sequential_divider_16x8;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [15:0] dividend  [2];
  logic [7:0]  divisor   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [7:0]  quotient  [2];
  logic [7:0]  remainder [2];
  logic        dbz       [2];
  logic        ovf       [2];

  sequential_divider_16x8 #(.APPROX_LSBS(0)) u_exact (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .dividend(dividend[0]), .divisor(divisor[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .quotient(quotient[0]), .remainder(remainder[0]),
    .div_by_zero(dbz[0]), .overflow(ovf[0])
  );

  sequential_divider_16x8 #(.APPROX_LSBS(2)) u_approx (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .dividend(dividend[1]), .divisor(divisor[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .quotient(quotient[1]), .remainder(remainder[1]),
    .div_by_zero(dbz[1]), .overflow(ovf[1])
  );

  typedef struct {
    int          d;
    logic [15:0] dvd;
    logic [7:0]  dvs;
    int          hold;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Plain-arithmetic reference: exact quotient, then drop skipped LSBs.
  function automatic vec_t model(input int d, input logic [15:0] dvd,
                                 input logic [7:0] dvs);
    vec_t v;
    int a, qe;
    a = (d == 1) ? 2 : 0;
    v.d = d; v.dvd = dvd; v.dvs = dvs; v.hold = 0;
    v.dbz = 1'b0; v.ovf = 1'b0;
    if (dvs == 8'd0) begin
      v.q = 8'hFF; v.r = dvd[7:0]; v.dbz = 1'b1; v.lat = 1;
    end else if (int'(dvd[15:8]) >= int'(dvs)) begin
      v.q = 8'hFF; v.r = 8'h00; v.ovf = 1'b1; v.lat = 1;
    end else begin
      qe = int'(dvd) / int'(dvs);
      v.q = 8'((qe >> a) << a);
      v.r = (a == 0) ? 8'(int'(dvd) % int'(dvs)) : 8'h00;
      v.lat = 8 - a + 1;
    end
    return v;
  endfunction

  task automatic run_op(input vec_t v, input string tag);
    int d, lat;
    logic [7:0] q0, r0;
    logic f0, g0;
    bit stable;
    d = v.d;
    lat = 0;
    while (!in_ready[d] && lat < 50) begin
      @(posedge CLK); #1; lat++;
    end
    check($sformatf("%s.idle", tag), int'(in_ready[d]), 1);
    in_valid[d]  = 1'b1;
    dividend[d]  = v.dvd;
    divisor[d]   = v.dvs;
    out_ready[d] = 1'b0;
    @(posedge CLK); #1;
    lat = 1;
    // Operand noise after accept must not disturb the result.
    dividend[d] = 16'($urandom);
    divisor[d]  = 8'($urandom);
    while (!out_valid[d] && lat < 40) begin
      @(posedge CLK); #1; lat++;
      dividend[d] = 16'($urandom);
      divisor[d]  = 8'($urandom);
    end
    check($sformatf("%s.lat", tag), lat, v.lat);
    check($sformatf("%s.q", tag), int'(quotient[d]), int'(v.q));
    check($sformatf("%s.r", tag), int'(remainder[d]), int'(v.r));
    check($sformatf("%s.dbz", tag), int'(dbz[d]), int'(v.dbz));
    check($sformatf("%s.ovf", tag), int'(ovf[d]), int'(v.ovf));
    q0 = quotient[d]; r0 = remainder[d]; f0 = dbz[d]; g0 = ovf[d];
    stable = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      @(posedge CLK); #1;
      if (quotient[d] !== q0 || remainder[d] !== r0 || dbz[d] !== f0 ||
          ovf[d] !== g0 || in_ready[d] !== 1'b0 || out_valid[d] !== 1'b1)
        stable = 1'b0;
    end
    check($sformatf("%s.hold", tag), int'(stable), 1);
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    @(posedge CLK); #1;
    out_ready[d] = 1'b0;
    check($sformatf("%s.ready_after", tag), int'(in_ready[d]), 1);
    check($sformatf("%s.valid_after", tag), int'(out_valid[d]), 0);
    check($sformatf("%s.q_kept", tag), int'(quotient[d]), int'(v.q));
  endtask

  vec_t tbl[9];
  vec_t rv;
  bit   seen;
  int   sel;
  logic [7:0]  rdvs;
  logic [15:0] rdvd;

  initial begin
    tbl[0] = '{0, 16'd1000,  8'd10,   0, 8'd100,  8'd0,   1'b0, 1'b0, 9};
    tbl[1] = '{0, 16'h0FFF,  8'h10,   0, 8'hFF,   8'h0F,  1'b0, 1'b0, 9};
    tbl[2] = '{0, 16'h1000,  8'h10,   0, 8'hFF,   8'h00,  1'b0, 1'b1, 1};
    tbl[3] = '{0, 16'h1234,  8'h00,   0, 8'hFF,   8'h34,  1'b1, 1'b0, 1};
    tbl[4] = '{1, 16'd1023,  8'd10,   0, 8'd100,  8'd0,   1'b0, 1'b0, 7};
    tbl[5] = '{0, 16'hFEFF,  8'hFF,   2, 8'd255,  8'd254, 1'b0, 1'b0, 9};
    tbl[6] = '{0, 16'd1000,  8'd10,  20, 8'd100,  8'd0,   1'b0, 1'b0, 9};
    tbl[7] = '{1, 16'h1234,  8'h00,   3, 8'hFF,   8'h34,  1'b1, 1'b0, 1};
    tbl[8] = '{0, 16'd5,     8'd7,    1, 8'd0,    8'd5,   1'b0, 1'b0, 9};

    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0;
      dividend[i] = '0; divisor[i] = '0;
    end
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    check("rst.in_ready", int'(in_ready[0]), 1);
    check("rst.out_valid", int'(out_valid[0]), 0);
    check("rst.q", int'(quotient[0]), 0);
    check("rst.r", int'(remainder[0]), 0);
    check("rst.flags", int'({dbz[0], ovf[0]}), 0);

    for (int i = 0; i < 9; i++)
      run_op(tbl[i], $sformatf("vec%0d", i));

    // Reset in the third BUSY cycle discards the operation.
    in_valid[0] = 1'b1; dividend[0] = 16'd2000; divisor[0] = 8'd9;
    @(posedge CLK); #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("busy_rst.in_ready", int'(in_ready[0]), 1);
    check("busy_rst.out_valid", int'(out_valid[0]), 0);
    check("busy_rst.q", int'(quotient[0]), 0);
    check("busy_rst.r", int'(remainder[0]), 0);
    check("busy_rst.flags", int'({dbz[0], ovf[0]}), 0);
    seen = 1'b0;
    repeat (15) begin
      @(posedge CLK); #1;
      if (out_valid[0]) seen = 1'b1;
    end
    check("busy_rst.no_valid", int'(seen), 0);

    for (int i = 0; i < 150; i++) begin
      sel  = $urandom_range(0, 7);
      rdvs = (sel == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (sel <= 1 || rdvs == 8'd0) rdvd = 16'($urandom);
      else rdvd = 16'($urandom_range(0, int'(rdvs) * 256 - 1));
      rv = model($urandom_range(0, 1), rdvd, rdvs);
      rv.hold = $urandom_range(0, 3);
      run_op(rv, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
